// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared frame write/read constants and state encoding
//
// Contents:
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default geometry shared with the read-side address controller
//   ST_IDLE / ST_FILL / ST_FULL      : frame controller state encoding
package frame_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

endpackage

// File: rtl/addr_bitrev.sv
// rtl/addr_bitrev.sv - combinational ADDR_W-bit address reversal with bypass
//
// Ports:
//   i_addr : linear address in
//   o_addr : bit-reversed address when BIT_REV != 0, otherwise i_addr unchanged
module addr_bitrev
  import frame_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int BIT_REV = 0
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [ADDR_W-1:0] o_addr
);

  if (BIT_REV != 0) begin : g_rev
    for (genvar i = 0; i < ADDR_W; i++) begin : g_bit
      assign o_addr[i] = i_addr[ADDR_W-1-i];
    end
  end else begin : g_pass
    assign o_addr = i_addr;
  end

endmodule

// File: rtl/frame_wr_ctrl.sv
// rtl/frame_wr_ctrl.sv - one-frame-per-start sample capture into a block RAM write port
//
// Ports:
//   i_clk, i_rst                   : clock, synchronous active-high reset
//   i_start, i_abort, i_release    : frame control pulses
//   i_s_valid, i_s_data, o_s_ready : sample input handshake
//   o_wr_en, o_wr_addr, o_wr_data  : registered RAM write port (1-cycle latency)
//   o_busy, o_done, o_frame_ready  : frame status
//   o_frame_cnt                    : completed frame count, wraps at 256
module frame_wr_ctrl
  import frame_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int BIT_REV = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_s_valid,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_s_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_frame_ready,
  input  logic              i_release,
  output logic [7:0]        o_frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_CNT = '1;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_done;
  logic [7:0]        r_frame_cnt;

  logic              w_fill;
  logic              w_hs;
  logic              w_last;
  logic [ADDR_W-1:0] w_map;

  assign w_fill = (r_state == ST_FILL);
  // abort wins over a sample presented in the same cycle: that sample is dropped, not written
  assign w_hs   = w_fill & i_s_valid & ~i_abort;
  assign w_last = w_hs & (r_cnt == LAST_CNT);

  addr_bitrev #(
    .ADDR_W  (ADDR_W),
    .BIT_REV (BIT_REV)
  ) u_map (
    .i_addr (r_cnt),
    .o_addr (w_map)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_wr_en <= w_hs;
      r_done  <= w_last;
      if (w_hs) begin
        r_wr_addr <= w_map;
        r_wr_data <= i_s_data;
      end
      if (w_last) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
          end
        end
        ST_FILL: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
          end else if (w_hs) begin
            // the increment past N-1 wraps to 0, harmless since the state leaves FILL
            r_cnt <= r_cnt + ADDR_W'(1);
            if (w_last) begin
              r_state <= ST_FULL;
            end
          end
        end
        ST_FULL: begin
          // release together with start chains straight into the next frame
          if (i_release && i_start) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
          end else if (i_release) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_s_ready     = w_fill;
  assign o_busy        = w_fill;
  assign o_frame_ready = (r_state == ST_FULL);
  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_done        = r_done;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_frame_wr_ctrl.sv
// tb/tb_frame_wr_ctrl.sv - scoreboard bench for frame_wr_ctrl (natural, bit-reversed, short-frame instances)
module tb_frame_wr_ctrl;

  typedef struct {
    int         cnt;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, s_valid, rel;
  logic [7:0] s_data;

  logic       s_ready0, wr_en0, busy0, done0, fr0;
  logic [9:0] wr_addr0;
  logic [7:0] wr_data0, fcnt0;

  logic       s_ready1, wr_en1, busy1, done1, fr1;
  logic [9:0] wr_addr1;
  logic [7:0] wr_data1, fcnt1;

  logic       start_s, abort_s, valid_s, rel_s;
  logic [7:0] data_s;
  logic       s_ready_s, wr_en_s, busy_s, done_s, fr_s;
  logic [2:0] wr_addr_s;
  logic [7:0] wr_data_s, fcnt_s;

  frame_wr_ctrl #(.DATA_W(8), .ADDR_W(10), .BIT_REV(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(s_ready0),
    .o_wr_en(wr_en0), .o_wr_addr(wr_addr0), .o_wr_data(wr_data0),
    .o_busy(busy0), .o_done(done0), .o_frame_ready(fr0),
    .i_release(rel), .o_frame_cnt(fcnt0)
  );

  frame_wr_ctrl #(.DATA_W(8), .ADDR_W(10), .BIT_REV(1)) u_dut_rev (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(s_ready1),
    .o_wr_en(wr_en1), .o_wr_addr(wr_addr1), .o_wr_data(wr_data1),
    .o_busy(busy1), .o_done(done1), .o_frame_ready(fr1),
    .i_release(rel), .o_frame_cnt(fcnt1)
  );

  frame_wr_ctrl #(.DATA_W(8), .ADDR_W(3), .BIT_REV(0)) u_dut_small (
    .i_clk(clk), .i_rst(rst), .i_start(start_s), .i_abort(abort_s),
    .i_s_valid(valid_s), .i_s_data(data_s), .o_s_ready(s_ready_s),
    .o_wr_en(wr_en_s), .o_wr_addr(wr_addr_s), .o_wr_data(wr_data_s),
    .o_busy(busy_s), .o_done(done_s), .o_frame_ready(fr_s),
    .i_release(rel_s), .o_frame_cnt(fcnt_s)
  );

  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  exp_t       qs[$];
  exp_t       e, es;
  int         exp_cnt;
  int         cnt_s;
  int         writes;
  int         dones;
  logic [7:0] ram [1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] rev10(input logic [9:0] a);
    logic [9:0] r;
    for (int k = 0; k < 10; k++) r[k] = a[9-k];
    return r;
  endfunction

  // scoreboard for the two 1024-deep instances, which see identical stimulus
  always @(negedge clk) begin
    if (wr_en0 || wr_en1 || done0) begin
      chk("wr_en_pair", {31'd0, wr_en1}, {31'd0, wr_en0});
      if (q.size() == 0) begin
        chk("unexpected_write", {31'd0, wr_en0}, 32'd0);
        chk("stray_done", {31'd0, done0}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("wr_en", {31'd0, wr_en0}, 32'd1);
        chk("wr_addr_nat", {22'd0, wr_addr0}, e.cnt);
        chk("wr_addr_rev", {22'd0, wr_addr1}, {22'd0, rev10(e.cnt[9:0])});
        chk("wr_data_nat", {24'd0, wr_data0}, {24'd0, e.data});
        chk("wr_data_rev", {24'd0, wr_data1}, {24'd0, e.data});
        chk("done_at_last", {31'd0, done0}, {31'd0, e.cnt == 1023});
        chk("done_pair", {31'd0, done1}, {31'd0, done0});
        ram[wr_addr1] = wr_data1;
        writes++;
        if (done0) dones++;
      end
    end
  end

  // scoreboard for the 8-deep instance
  always @(negedge clk) begin
    if (wr_en_s || done_s) begin
      if (qs.size() == 0) begin
        chk("small_unexpected_write", {31'd0, wr_en_s}, 32'd0);
      end else begin
        es = qs.pop_front();
        chk("small_wr_addr", {29'd0, wr_addr_s}, es.cnt);
        chk("small_wr_data", {24'd0, wr_data_s}, {24'd0, es.data});
        chk("small_done", {31'd0, done_s}, {31'd0, es.cnt == 7});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit gaps);
    if (gaps) begin
      for (int g = 0; g < 8 && $urandom_range(0, 1) == 0; g++) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        tick();
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk);
    q.push_back('{exp_cnt, d});
    exp_cnt++;
    #1;
    s_valid = 1'b0;
  endtask

  task automatic fill_frame(input bit gaps, input logic [7:0] exp_fcnt);
    exp_cnt = 0;
    writes  = 0;
    dones   = 0;
    for (int i = 0; i < 1024; i++) send(i[7:0], gaps);
    @(negedge clk);
    chk("done_last_write", {31'd0, done0}, 32'd1);
    chk("frame_ready", {31'd0, fr0}, 32'd1);
    chk("frame_cnt", {24'd0, fcnt0}, {24'd0, exp_fcnt});
    chk("frame_cnt_rev", {24'd0, fcnt1}, {24'd0, exp_fcnt});
    #1;
    chk("frame_writes", writes, 1024);
    chk("frame_dones", dones, 1);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; rel = 1'b0; s_data = 8'd0;
    start_s = 1'b0; abort_s = 1'b0; valid_s = 1'b0; rel_s = 1'b0; data_s = 8'd0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_wr_en", {31'd0, wr_en0}, 32'd0);
    chk("rst_wr_addr", {22'd0, wr_addr0}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_frame_ready", {31'd0, fr0}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready0}, 32'd0);
    chk("rst_frame_cnt", {24'd0, fcnt0}, 32'd0);
    tick();
    rst = 1'b0;
    // abort and release in IDLE do nothing
    abort = 1'b1; rel = 1'b1;
    tick();
    abort = 1'b0; rel = 1'b0;
    chk("idle_busy", {31'd0, busy0}, 32'd0);

    // frame 1: continuous stream, checks both address orders
    for (int i = 0; i < 1024; i++) ram[i] = 8'hxx;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fill_busy", {31'd0, busy0}, 32'd1);
    chk("fill_s_ready", {31'd0, s_ready0}, 32'd1);
    fill_frame(1'b0, 8'd1);
    chk("ram_rev_512", {24'd0, ram[512]}, 32'd1);
    chk("ram_rev_256", {24'd0, ram[256]}, 32'd2);
    chk("ram_rev_1023", {24'd0, ram[1023]}, 32'd255);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (ram[rev10(i[9:0])] !== i[7:0]) bad++;
    end
    chk("ram_rev_all", bad, 0);

    // FULL: samples refused, start alone and abort ignored
    s_valid = 1'b1; s_data = 8'hAA; start = 1'b1;
    tick();
    start = 1'b0;
    chk("full_start_alone", {31'd0, fr0}, 32'd1);
    chk("full_s_ready", {31'd0, s_ready0}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("full_abort_ignored", {31'd0, fr0}, 32'd1);
    tick();
    tick();
    s_valid = 1'b0;
    chk("full_no_writes", writes, 1024);

    // back-to-back: release + start, frame 2 with random gaps
    rel = 1'b1; start = 1'b1;
    tick();
    rel = 1'b0; start = 1'b0;
    chk("b2b_busy", {31'd0, busy0}, 32'd1);
    chk("b2b_frame_ready", {31'd0, fr0}, 32'd0);
    fill_frame(1'b1, 8'd2);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("release_idle_fr", {31'd0, fr0}, 32'd0);
    chk("release_idle_busy", {31'd0, busy0}, 32'd0);

    // abort at handshake 500
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cnt = 0;
    dones   = 0;
    for (int i = 0; i < 500; i++) send(i[7:0], 1'b0);
    s_valid = 1'b1; s_data = 8'h55; abort = 1'b1;
    tick();
    abort = 1'b0; s_valid = 1'b0;
    chk("abort_idle", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    chk("abort_no_write", {31'd0, wr_en0}, 32'd0);
    chk("abort_no_done", dones, 0);
    chk("abort_frame_cnt", {24'd0, fcnt0}, 32'd2);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    fill_frame(1'b1, 8'd3);
    rel = 1'b1;
    tick();
    rel = 1'b0;

    // reset mid-FILL
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) send(i[7:0], 1'b0);
    rst = 1'b1; s_valid = 1'b1; start = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_wr_en", {31'd0, wr_en0}, 32'd0);
    chk("midrst_wr_addr", {22'd0, wr_addr0}, 32'd0);
    chk("midrst_wr_data", {24'd0, wr_data0}, 32'd0);
    chk("midrst_busy", {31'd0, busy0}, 32'd0);
    chk("midrst_done", {31'd0, done0}, 32'd0);
    chk("midrst_frame_ready", {31'd0, fr0}, 32'd0);
    chk("midrst_s_ready", {31'd0, s_ready0}, 32'd0);
    chk("midrst_frame_cnt", {24'd0, fcnt0}, 32'd0);
    chk("midrst_queue", q.size(), 0);
    tick();
    rst = 1'b0; s_valid = 1'b0; start = 1'b0;

    // 256 back-to-back short frames: frame count wraps to 0
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int f = 0; f < 256; f++) begin
      cnt_s = 0;
      for (int i = 0; i < 8; i++) begin
        valid_s = 1'b1;
        data_s  = f[7:0] ^ i[7:0];
        @(posedge clk);
        qs.push_back('{cnt_s, data_s});
        cnt_s++;
        #1;
      end
      valid_s = 1'b0;
      @(negedge clk);
      chk("small_done_pulse", {31'd0, done_s}, 32'd1);
      chk("small_frame_cnt", {24'd0, fcnt_s}, (f + 1) % 256);
      rel_s = 1'b1; start_s = 1'b1;
      tick();
      rel_s = 1'b0; start_s = 1'b0;
    end
    chk("small_wrapped", {24'd0, fcnt_s}, 32'd0);
    chk("small_queue", qs.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_wr_ctrl.md
Name: frame_wr_ctrl

Overview:
- Write-side counterpart to the ROM/address-controller read path.
- Accepts a stream of DATA_W-bit samples over a valid/ready handshake and drives the write port of a 2^ADDR_W-deep simple dual-port block RAM.
- Address order is natural or bit-reversed, for FFT input staging.
- Fills exactly one frame per start command, then holds the frame until the downstream reader releases it.

Parameters:
- DATA_W, 8: sample width; matches the block RAM data width.
- ADDR_W, 10: RAM address width; frame length N = 2^ADDR_W = 1024.
- BIT_REV, 0: 0 = natural write order; 1 = bit-reversed write address.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; arms capture of one frame.
- abort  in  1  single-cycle pulse; cancels a frame in progress.
- s_valid  in  1  source has a sample on s_data.
- s_data  in  DATA_W  sample value.
- s_ready  out  1  block accepts a sample this cycle.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- busy  out  1  high while a frame is filling.
- done  out  1  one-cycle pulse, coincident with the last write of a frame.
- frame_ready  out  1  level; a full frame is held in the RAM.
- release  in  1  single-cycle pulse from the reader; the frame has been consumed.
- frame_cnt  out  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset (rst=1 at a clock edge) sets every output to 0, the state to IDLE and the sample counter to 0. Reset mid-frame discards the partial frame; no done pulse is produced.
- State IDLE:
  - s_ready=0, busy=0, frame_ready=0.
  - start=1 -> FILL; counter cleared to 0.
  - abort and release are ignored.
- State FILL:
  - s_ready=1 combinationally from state; busy=1.
  - A handshake (s_valid & s_ready) registers wr_en=1, wr_data=s_data and wr_addr=map(cnt) on the next edge. Write latency is 1 cycle; otherwise wr_en=0.
  - The counter increments on each handshake.
  - Handshake with cnt=N-1 -> FULL. On the same registered cycle as that final write, done=1 and frame_cnt increments.
  - abort=1 -> IDLE, with no write for any sample presented that cycle. abort has priority over a handshake in the same cycle.
  - start is ignored.
- State FULL:
  - s_ready=0, frame_ready=1.
  - release=1 -> IDLE.
  - release=1 and start=1 in the same cycle -> FILL directly, counter cleared. This allows back-to-back frames.
  - start alone and abort are ignored.
- Address map:
  - BIT_REV=0: map(cnt)=cnt.
  - BIT_REV=1: map(cnt)=cnt with bits reversed over ADDR_W; for ADDR_W=10, cnt=1 maps to 512.
- The counter is ADDR_W+0 bits and never wraps inside a frame, because the transition to FULL happens at N-1.
- When s_ready=0, s_valid is not consumed; the source holds its data and nothing is dropped.
- wr_en never asserts outside FILL plus one trailing cycle.

Decomposition:
- Shared package frame_pkg:
  - state encoding: IDLE=2'd0, FILL=2'd1, FULL=2'd2.
  - default DATA_W and ADDR_W constants, shared with the read-side address controller.
- One sub-module: addr_bitrev, a parameterised ADDR_W-bit reversal with a BIT_REV bypass. It is purely combinational and is reused by the reader.

Test Plan:
- Reset then start, then 1024 consecutive samples s_data=cnt[7:0] with BIT_REV=0:
  - wr_addr runs 0..1023 with wr_data matching, 1 cycle behind each handshake.
  - done pulses once with wr_addr=1023; frame_ready=1; frame_cnt=1.
- BIT_REV=1, same stream:
  - handshake 1 writes addr 512; handshake 2 writes 256; handshake 1023 writes 1023.
  - A RAM model holds data[bitrev(i)]=i.
- Random s_valid gaps (~50% duty):
  - exactly 1024 writes, in order, with no duplicates.
  - s_valid asserted in FULL is not accepted (s_ready=0).
- abort at handshake 500:
  - state IDLE next cycle; no done pulse; frame_cnt unchanged.
  - a following start restarts at addr 0.
- In FULL, start+release in the same cycle:
  - re-enters FILL; first write at addr 0.
  - start alone in FULL leaves frame_ready=1.
- rst asserted mid-FILL, and 256 frames run back-to-back:
  - after rst, all outputs are 0 on the next edge.
  - frame_cnt wraps from 255 to 0 on the 256th completed frame.
